lsu: RTL and testbench

Load/store unit for the tiny-riscv core. Accepts one memory operation at a time from decode, issues it on a valid/ready data-memory bus, and returns a one-cycle load writeback pulse (`ld_valid`/`ld_rd`/`ld_data`) to the core control and register file. Acceptance of new loads and stores is gated by the control block's `ld_en`/`st_en`. The unit also performs byte-lane steering, sign extension and misalignment detection.

---
 rtl/lsu.sv | 149 ++++++++++++++
 tb/tb_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one memory op at a time over a valid/ready data bus, with
// byte-lane steering, sign/zero extension and misalignment rejection.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_rd,
  input  logic        ld_en,
  input  logic        st_en,
  output logic        lsu_busy,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic [4:0]  op_rd;

  logic        req_gate;
  logic        op_legal;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  assign lsu_busy = (state != IDLE);
  assign req_gate = mem_valid & (mem_store ? st_en : ld_en);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    op_legal = 1'b0;
    st_strb  = 4'b0000;
    st_data  = mem_wdata;
    if (mem_store) begin
      case (mem_funct3)
        3'b000: begin
          op_legal = 1'b1;
          st_strb  = 4'b0001 << mem_addr[1:0];
          st_data  = {4{mem_wdata[7:0]}};
        end
        3'b001: begin
          op_legal = ~mem_addr[0];
          st_strb  = mem_addr[1] ? 4'b1100 : 4'b0011;
          st_data  = {2{mem_wdata[15:0]}};
        end
        3'b010: begin
          op_legal = (mem_addr[1:0] == 2'b00);
          st_strb  = 4'b1111;
        end
        default: op_legal = 1'b0;
      endcase
    end else begin
      case (mem_funct3)
        3'b000, 3'b100: op_legal = 1'b1;
        3'b001, 3'b101: op_legal = ~mem_addr[0];
        3'b010:         op_legal = (mem_addr[1:0] == 2'b00);
        default:        op_legal = 1'b0;
      endcase
    end
  end

  function automatic logic [31:0] extend(input logic [2:0]  funct3,
                                         input logic [1:0]  lane,
                                         input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lane +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_funct3 <= 3'd0;
      op_lane   <= 2'd0;
      op_rd     <= 5'd0;
      mem_fault <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
      ld_valid  <= 1'b0;
      ld_rd     <= 5'd0;
      ld_data   <= 32'd0;
    end else begin
      mem_fault <= 1'b0;
      ld_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_gate && op_legal) begin
            state     <= REQ;
            op_funct3 <= mem_funct3;
            op_lane   <= mem_addr[1:0];
            op_rd     <= mem_rd;
            bus_req   <= 1'b1;
            bus_we    <= mem_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wstrb <= mem_store ? st_strb : 4'b0000;
            bus_wdata <= mem_store ? st_data : 32'd0;
          end else if (req_gate) begin
            mem_fault <= 1'b1;
          end
        end
        REQ: begin
          // bus_req is high throughout REQ, so bus_ready alone completes the handshake.
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= bus_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            state    <= IDLE;
            ld_valid <= 1'b1;
            ld_rd    <= op_rd;
            ld_data  <= extend(op_funct3, op_lane, bus_rdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a rule-level reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_store;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic [4:0]  mem_rd;
  logic        ld_en, st_en;
  logic        lsu_busy, mem_fault, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_store(mem_store), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .ld_en(ld_en), .st_en(st_en),
    .lsu_busy(lsu_busy), .mem_fault(mem_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data)
  );

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * a[1:0])) & 32'hFF;
    h = (r >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return r;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int s;
    if (!st) return 4'd0;
    case (f3)
      3'd0:    s = 1 << (a % 4);
      3'd1:    s = 3 << (2 * ((a / 2) % 2));
      default: s = 15;
    endcase
    return 4'(s);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return (w & 32'hFF) * 32'h01010101;
      3'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op through the full protocol and checks every observable phase.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [4:0] rd, input int rdy_dly, input int rv_dly);
    logic [38:0] obs, exp;
    logic [31:0] e_ld;
    ld_en = 1'b1; st_en = 1'b1;
    mem_valid = 1'b1; mem_store = st; mem_funct3 = f3;
    mem_addr = addr; mem_wdata = wdata; mem_rd = rd;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    step();
    mem_valid = 1'b0;
    if (!m_legal(st, f3, addr)) begin
      n_cmp++;
      if ({lsu_busy, mem_fault, bus_req} !== 3'b010) begin
        n_err++;
        $display("FAIL fault_pulse st=%0d f3=%0d addr=%h: busy/fault/req got %b want 010",
                 st, f3, addr, {lsu_busy, mem_fault, bus_req});
      end
      step();
      n_cmp++;
      if ({lsu_busy, mem_fault, bus_req} !== 3'b000) begin
        n_err++;
        $display("FAIL fault_clear: busy/fault/req got %b want 000",
                 {lsu_busy, mem_fault, bus_req});
      end
      return;
    end
    // Flush after acceptance must not disturb the in-flight op.
    ld_en = 1'($urandom); st_en = 1'($urandom);
    exp = {1'b1, 1'b0, 1'b1, st, addr & ~32'h3, m_strb(st, f3, addr)};
    for (int i = 0; i <= rdy_dly; i++) begin
      obs = {lsu_busy, mem_fault, bus_req, bus_we, bus_addr, bus_wstrb};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL req_outputs cyc=%0d: got %h want %h", i, obs, exp);
      end
      if (st) begin
        n_cmp++;
        if (bus_wdata !== m_wdata(f3, wdata)) begin
          n_err++;
          $display("FAIL store_wdata: got %h want %h", bus_wdata, m_wdata(f3, wdata));
        end
      end
      if (i == rdy_dly) break;
      // While stalled, a second op and a stray rvalid must both be ignored.
      mem_valid = 1'b1; mem_store = 1'($urandom); mem_funct3 = 3'($urandom);
      mem_addr = $urandom; bus_rvalid = 1'($urandom);
      step();
      mem_valid = 1'b0; bus_rvalid = 1'b0;
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    n_cmp++;
    if ({lsu_busy, bus_req, ld_valid} !== {~st, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL post_handshake: busy/req/ldv got %b want %b",
               {lsu_busy, bus_req, ld_valid}, {~st, 2'b00});
    end
    if (st) return;
    for (int i = 0; i < rv_dly; i++) begin
      step();
      n_cmp++;
      if ({lsu_busy, ld_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL resp_wait: busy/ldv got %b want 10", {lsu_busy, ld_valid});
      end
    end
    bus_rvalid = 1'b1; bus_rdata = rdata;
    step();
    bus_rvalid = 1'b0; bus_rdata = $urandom;
    e_ld = m_load(f3, addr, rdata);
    n_cmp++;
    if ({lsu_busy, ld_valid, ld_rd, ld_data} !== {1'b0, 1'b1, rd, e_ld}) begin
      n_err++;
      $display("FAIL load_wb f3=%0d addr=%h: busy/ldv/rd/data got %b/%b/%0d/%h want 0/1/%0d/%h",
               f3, addr, lsu_busy, ld_valid, ld_rd, ld_data, rd, e_ld);
    end
    step();
    n_cmp++;
    if ({ld_valid, ld_rd, ld_data} !== {1'b0, rd, e_ld}) begin
      n_err++;
      $display("FAIL load_hold: ldv/rd/data got %b/%0d/%h want 0/%0d/%h",
               ld_valid, ld_rd, ld_data, rd, e_ld);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [109:0] all;
    reset = 1'b1;
    mem_valid = 0; mem_store = 0; mem_funct3 = 0; mem_addr = 0; mem_wdata = 0; mem_rd = 0;
    ld_en = 1; st_en = 1; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    step(); step();
    all = {lsu_busy, mem_fault, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
           ld_valid, ld_rd, ld_data};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", all);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_op(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 5'd9, 0, 0);
    run_op(0, 3'd0, 32'h203, 0, 32'h80FF_FFFF, 5'd3, 0, 0);
    run_op(0, 3'd4, 32'h203, 0, 32'h80FF_FFFF, 5'd4, 0, 1);
    run_op(0, 3'd1, 32'h202, 0, 32'h8001_0000, 5'd0, 1, 0);
    run_op(1, 3'd0, 32'h11, 32'h0000_00AB, 0, 5'd0, 0, 0);
    run_op(1, 3'd1, 32'h12, 32'h0000_1234, 0, 5'd0, 2, 0);
  endtask

  task automatic test_misaligned();
    run_op(0, 3'd2, 32'h102, 0, 0, 5'd1, 0, 0);
    run_op(1, 3'd1, 32'h101, 32'h55, 0, 5'd0, 0, 0);
    run_op(0, 3'd3, 32'h100, 0, 0, 5'd1, 0, 0);
    run_op(1, 3'd4, 32'h100, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 3'd2, 32'h340, 0, 32'h0BAD_F00D, 5'd17, 4, 2);
  endtask

  task automatic test_gating();
    bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_en = (i == 1); st_en = (i != 1);
      mem_valid = 1'b1; mem_store = (i == 1);
      mem_funct3 = (i == 2) ? 3'd2 : 3'd1;
      mem_addr = (i == 2) ? 32'h102 : 32'h100;
      step();
      mem_valid = 1'b0;
      n_cmp++;
      if ({lsu_busy, mem_fault, bus_req} !== 3'b000) begin
        n_err++;
        $display("FAIL gated_off case=%0d: busy/fault/req got %b want 000",
                 i, {lsu_busy, mem_fault, bus_req});
      end
      step();
    end
    bus_ready = 1'b0; ld_en = 1'b1; st_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    ld_en = 1; st_en = 1; bus_ready = 1'b1;
    mem_valid = 1; mem_store = 0; mem_funct3 = 3'd2; mem_addr = 32'h40; mem_rd = 5'd7;
    step();
    mem_valid = 0;
    step();
    bus_rvalid = 1; bus_rdata = 32'h1234_5678;
    mem_valid = 1; mem_store = 1; mem_funct3 = 3'd2; mem_addr = 32'h80; mem_wdata = 32'hCAFE_F00D;
    step();
    bus_rvalid = 0;
    n_cmp++;
    if ({lsu_busy, ld_valid, ld_rd, ld_data} !== {1'b0, 1'b1, 5'd7, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL b2b_load: busy/ldv/rd/data got %b/%b/%0d/%h want 0/1/7/12345678",
               lsu_busy, ld_valid, ld_rd, ld_data);
    end
    step();
    mem_valid = 0;
    n_cmp++;
    if ({lsu_busy, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, ld_valid} !==
        {3'b111, 32'h80, 4'hF, 32'hCAFE_F00D, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_store_accept: got %b %b %b %h %b %h %b", lsu_busy, bus_req, bus_we,
               bus_addr, bus_wstrb, bus_wdata, ld_valid);
    end
    step();
    bus_ready = 0;
    n_cmp++;
    if ({lsu_busy, bus_req} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_store_done: busy/req got %b want 00", {lsu_busy, bus_req});
    end
  endtask

  task automatic test_reset_mid_op();
    logic [109:0] all;
    ld_en = 1; bus_ready = 1'b1;
    mem_valid = 1; mem_store = 0; mem_funct3 = 3'd2; mem_addr = 32'h500; mem_rd = 5'd12;
    step();
    mem_valid = 0;
    step();
    bus_ready = 0;
    reset = 1'b1;
    #1;
    all = {lsu_busy, mem_fault, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
           ld_valid, ld_rd, ld_data};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL reset_mid_op: got %h want 0", all);
    end
    step();
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({lsu_busy, bus_req, ld_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL stray_rvalid cyc=%0d: busy/req/ldv got %b want 000",
                 i, {lsu_busy, bus_req, ld_valid});
      end
      step();
    end
    run_op(0, 3'd2, 32'h500, 0, 32'h0A0B_0C0D, 5'd12, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      // Bias toward aligned addresses so most ops reach the bus.
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
      run_op(1'($urandom), 3'($urandom), a, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_backpressure();
    test_gating();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
